// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The ImmSrc codes must match the immediate extender's selector encoding.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: return IMM_I;
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps ALUOp plus the instruction's function fields to an ALU operation.
module alu_dec
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        op5_i,
  input  logic        funct7b5_i,
  output logic [2:0]  alu_control_o
);

  // NOTE: assign a default first in every combinational block so no path leaves the output unassigned (latch).
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle control FSM for the RV32 core: sequences fetch/decode/execute over
// a shared datapath and stalls on the memory handshake.
module riscv_mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic [2:0] alu_control;

  // NOTE: reset is synchronous, so it lives inside the clocked block and only acts on an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    alu_op        = ALUOP_ADD;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    RegWrite      = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_SUB;
        PCWrite = zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides everything so an abandoned instruction cannot strobe.
    if (!reset_n) begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RD2;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control)
  );

  assign ALUControl = reset_n ? alu_control : ALU_ADD;
  assign ImmSrc     = reset_n ? imm_src_of(op) : IMM_I;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: instruction-level model pushes the
// expected per-cycle control word, a negedge monitor pops and compares.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  riscv_mc_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUControl    (ALUControl),
    .RegWrite      (RegWrite),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       regw;
    logic       ill;
  } exp_t;

  exp_t  scb[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Quiet control word for a live (non-reset) cycle: only ImmSrc follows op.
  function automatic exp_t idle(input logic [6:0] o);
    exp_t e;
    e     = '0;
    e.imm = imm_of(o);
    return e;
  endfunction

  task automatic step(input exp_t e, input logic ready, input string tag);
    mem_ready = ready;
    scb.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_step(input string tag);
    reset_n = 1'b0;
    step('0, rnd_bit(), tag);
    reset_n = 1'b1;
  endtask

  task automatic aluwb(input logic [6:0] o, input string name);
    exp_t e;
    e      = idle(o);
    e.regw = 1'b1;
    step(e, rnd_bit(), {name, " aluwb"});
  endtask

  // Expected control sequence for one instruction, cycle by cycle.
  task automatic exec_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fstall, input int mstall,
                            input bit rst_in_mem, input string name);
    exp_t e;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;

    e     = idle(o);
    e.res = 2'b10;
    e.sb  = 2'b10;
    for (int i = 0; i < fstall; i++) step(e, 1'b0, {name, " fetch-wait"});
    e.irw = 1'b1;
    e.pcw = 1'b1;
    step(e, 1'b1, {name, " fetch"});

    e    = idle(o);
    e.sa = 2'b01;
    e.sb = 2'b01;
    if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})) begin
      e.ill = 1'b1;
      step(e, rnd_bit(), {name, " decode-illegal"});
      return;
    end
    step(e, rnd_bit(), {name, " decode"});

    case (o)
      7'b0000011, 7'b0100011: begin
        e    = idle(o);
        e.sa = 2'b10;
        e.sb = 2'b01;
        step(e, rnd_bit(), {name, " memadr"});
        e     = idle(o);
        e.adr = 1'b1;
        if (o == 7'b0000011) begin
          for (int i = 0; i < mstall; i++) step(e, 1'b0, {name, " memread-wait"});
          if (rst_in_mem) begin
            rst_step({name, " reset-in-memread"});
            return;
          end
          step(e, 1'b1, {name, " memread"});
          e      = idle(o);
          e.res  = 2'b01;
          e.regw = 1'b1;
          step(e, rnd_bit(), {name, " memwb"});
        end else begin
          e.memw = 1'b1;
          for (int i = 0; i < mstall; i++) step(e, 1'b0, {name, " memwrite-wait"});
          step(e, 1'b1, {name, " memwrite"});
        end
      end
      7'b0110011, 7'b0010011: begin
        e     = idle(o);
        e.sa  = 2'b10;
        e.sb  = (o == 7'b0110011) ? 2'b00 : 2'b01;
        e.alu = funct_alu(f3, o[5], f7);
        step(e, rnd_bit(), {name, " execute"});
        aluwb(o, name);
      end
      7'b1100011: begin
        e     = idle(o);
        e.sa  = 2'b10;
        e.alu = 3'b001;
        e.pcw = z;
        step(e, rnd_bit(), {name, " beq"});
      end
      default: begin
        e     = idle(o);
        e.sa  = 2'b01;
        e.sb  = 2'b10;
        e.pcw = 1'b1;
        step(e, rnd_bit(), {name, " jal"});
        aluwb(o, name);
      end
    endcase
  endtask

  exp_t  act, exp_v;
  string tag;

  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_v = scb.pop_front();
      tag   = tag_q.pop_front();
      act   = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite, illegal_instr};
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL %s @%0t: got %h want %h (pcw adr memw irw res sa sb imm alu regw ill)",
                 tag, $time, act, exp_v);
      end
    end
  end

  localparam logic [6:0] LEGAL_OPS [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                          7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    logic [6:0] o;
    @(posedge clk);
    #1;
    rst_step("reset-0");
    rst_step("reset-1");

    exec_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, "lw");
    exec_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0, "sw-wait3");
    exec_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, "sub");
    exec_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, "addi");
    exec_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, "beq-taken");
    exec_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "beq-not");
    exec_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "jal");
    exec_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "illegal");
    exec_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 1, 1'b1, "lw-reset");
    exec_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 2, 0, 1'b0, "and-after-reset");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        o = 7'($urandom);
        if (o inside {LEGAL_OPS}) o = 7'b1111111;
      end else begin
        o = LEGAL_OPS[$urandom_range(0, 5)];
      end
      exec_instr(o, 3'($urandom), rnd_bit(), rnd_bit(), $urandom_range(0, 2),
                 $urandom_range(0, 3), ($urandom_range(0, 15) == 0), "rand");
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (scb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard-drain: got %0d pending want 0", scb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
